ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The module SHALL have parameter SIZE, default 14, giving the RAM address width in bits.
REQ-002 The module SHALL have parameter BURST_MAX, default 4, giving the maximum consecutive grants to one requester while the other is waiting.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have ports req0/req1, input, 1 bit each: access request from requester 0 (CPU) and requester 1 (loader/debug).
REQ-006 The module SHALL have ports we0/we1, input, 1 bit each: write enable (1) or read (0) qualifying reqN.
REQ-007 The module SHALL have ports addr0/addr1, input, SIZE bits each: word address.
REQ-008 The module SHALL have ports wdata0/wdata1, input, 32 bits each: write data.
REQ-009 The module SHALL have ports gnt0/gnt1, output, 1 bit each: access accepted this cycle (combinational).
REQ-010 The module SHALL have ports rvalid0/rvalid1, output, 1 bit each: read data valid (registered).
REQ-011 The module SHALL have ports rdata0/rdata1, output, 32 bits each: read data, both driven from ram_rdata.
REQ-012 The module SHALL have ports ram_we (output, 1), ram_addr (output, SIZE), ram_wdata (output, 32) and ram_rdata (input, 32): the blram port, with 1-cycle read latency.

Function
REQ-013 The FSM SHALL have states IDLE, OWN0 and OWN1, and SHALL keep a burst counter cnt (0..BURST_MAX) and a last-served pointer lsp.
REQ-014 Grant: at most one of gnt0/gnt1 SHALL be high per cycle, and gntN SHALL only be high while reqN is high.
REQ-015 Selection in IDLE: a sole requester SHALL win; if both request, the requester other than lsp SHALL win.
REQ-016 Selection in OWNn: owner n SHALL keep the grant while reqn is high, unless the other requester is waiting and cnt == BURST_MAX, in which case the other SHALL win.
REQ-017 If the owner drops req, the other requester (if requesting) SHALL be granted in that same cycle; otherwise the next state SHALL be IDLE.
REQ-018 On a grant to requester k, the next state SHALL be OWNk; cnt SHALL become 1 on an owner change and increment (saturating at BURST_MAX) on a continued grant; lsp SHALL become k.
REQ-019 With no grant, the next state SHALL be IDLE, cnt SHALL be 0, and lsp SHALL be unchanged.
REQ-020 RAM mux: ram_addr/ram_wdata SHALL follow the granted requester; ram_we SHALL equal weK & gntK; with no grant, ram_we=0 and ram_addr/ram_wdata SHALL take requester 0's values (don't-care).
REQ-021 Read return: rvalidK SHALL be high in the cycle after a granted read by requester K, for exactly one cycle per granted read; a granted write SHALL produce no rvalid.
REQ-022 Back-to-back reads SHALL sustain one read per cycle, and a read immediately after a write to the same address SHALL return the new data.
REQ-023 A request not granted SHALL be held by the requester; the arbiter SHALL not queue requests.
REQ-024 BURST_MAX=1 SHALL degenerate to strict alternation under contention.

Reset
REQ-025 While rst=1: state=IDLE, cnt=0, lsp=1 (so requester 0 wins the first tie), gnt0=gnt1=0, ram_we=0, rvalid0=rvalid1=0.
REQ-026 A read granted in the cycle rst asserts SHALL produce no rvalid, and in-flight reads SHALL be dropped.
REQ-027 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE/OWN0/OWN1) and the defaults SIZE=14, DATA_W=32 and BURST_MAX=4.
REQ-029 No sub-module is required; the module instantiates no RAM, and the bench connects it to blram.

Verification
REQ-030 Single requester: req0 reads addr 150 holding 9 -> gnt0 the same cycle, rvalid0=1 next cycle with rdata0=9, gnt1 stays 0.
REQ-031 Tie after reset: both request reads of 151/152 continuously, BURST_MAX=4 -> gnt0 for 4 cycles, then gnt1 for 4, alternating; rdata returns 5 and 12 respectively.
REQ-032 Write-then-read: req1 writes 0x0000_0065 to addr 98, then reads 98 -> rvalid1 with 0x65; no rvalid after the write.
REQ-033 Owner drop: req0 owns, req1 waiting, req0 deasserts at cnt=2 -> gnt1 in that same cycle, cnt=1.
REQ-034 Reset mid-read: rst asserted in the cycle of a granted read -> no rvalid; state IDLE; the next tie goes to requester 0.
REQ-035 Idle: no requests for 10 cycles -> ram_we=0, no gnt, no rvalid throughout.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-requester RAM port arbiter: FSM encoding
// and default geometry.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int SIZE_DEFAULT      = 14;
  localparam int DATA_W            = 32;
  localparam int BURST_MAX_DEFAULT = 4;

endpackage

// File: rtl/ram_port_arbiter.sv
// Arbitrates a CPU port and a loader/debug port onto one single-port block RAM,
// bounding the burst length of the owner while the other requester waits.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int SIZE      = SIZE_DEFAULT,
  parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [SIZE-1:0]   addr0,
  input  logic [SIZE-1:0]   addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [SIZE-1:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lsp_q, lsp_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;

  // Grant selection; an exhausted burst yields to a waiting requester.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      OWN0: begin
        if (req0 && !(req1 && cnt_q == CNT_MAX)) gnt0 = 1'b1;
        else                                      gnt1 = req1;
      end
      OWN1: begin
        if (req1 && !(req0 && cnt_q == CNT_MAX)) gnt1 = 1'b1;
        else                                      gnt0 = req0;
      end
      default: begin
        if (req0 && req1) begin
          gnt0 = lsp_q;
          gnt1 = !lsp_q;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    lsp_d   = lsp_q;
    if (gnt0) begin
      state_d = OWN0;
      lsp_d   = 1'b0;
      cnt_d   = (state_q != OWN0) ? CNT_W'(1) :
                (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end else if (gnt1) begin
      state_d = OWN1;
      lsp_d   = 1'b1;
      cnt_d   = (state_q != OWN1) ? CNT_W'(1) :
                (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lsp_q     <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lsp_q     <= lsp_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Masking with rst drops a read that is still in flight when reset arrives.
  assign rvalid0   = rvalid0_q & ~rst;
  assign rvalid1   = rvalid1_q & ~rst;
  assign rdata0    = ram_rdata;
  assign rdata1    = ram_rdata;
  assign ram_we    = (gnt0 & we0) | (gnt1 & we1);
  assign ram_addr  = gnt1 ? addr1  : addr0;
  assign ram_wdata = gnt1 ? wdata1 : wdata0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Drives the arbiter against a behavioural block RAM and compares every cycle
// with a requester-level reference model of the arbitration rules.
module tb_ram_port_arbiter;

  localparam int SIZE = 14;
  localparam int BM   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0, req1, we0, we1;
  logic [SIZE-1:0] addr0, addr1;
  logic [31:0]     wdata0, wdata1;
  logic            gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0]     rdata0, rdata1;
  logic            ram_we;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_rdata;

  logic [31:0] mem     [0:(1<<SIZE)-1];
  logic [31:0] ref_mem [0:(1<<SIZE)-1];

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state, kept in terms of "who owns the port" and "how long".
  int          m_owner;
  int          m_streak;
  int          m_last;
  bit          exp_rv [2];
  logic [31:0] exp_rd [2];
  bit          seen_gnt [2];

  ram_port_arbiter #(.SIZE(SIZE), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural block RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Applies one cycle of inputs, checks the outputs mid-cycle, then advances the model.
  task automatic applyStimulus(input logic r, input logic rq0, input logic rq1,
                               input logic w0, input logic w1,
                               input logic [SIZE-1:0] a0, input logic [SIZE-1:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1);
    bit          rq [2];
    bit          wk [2];
    logic [SIZE-1:0] ak [2];
    logic [31:0] dk [2];
    int          win;
    int          other;
    bit          exp_we;
    rst = r; req0 = rq0; req1 = rq1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    rq[0] = rq0; rq[1] = rq1; wk[0] = w0; wk[1] = w1;
    ak[0] = a0;  ak[1] = a1;  dk[0] = d0; dk[1] = d1;
    @(negedge clk);

    win = -1;
    if (!r) begin
      if (m_owner < 0) begin
        if (rq[0] && rq[1]) win = 1 - m_last;
        else if (rq[0])     win = 0;
        else if (rq[1])     win = 1;
      end else begin
        other = 1 - m_owner;
        if (rq[m_owner] && !(rq[other] && m_streak >= BM)) win = m_owner;
        else if (rq[other])                                 win = other;
      end
    end
    exp_we = (win >= 0) && wk[win];

    checkOutput("gnt0", {31'd0, gnt0}, {31'd0, win == 0});
    checkOutput("gnt1", {31'd0, gnt1}, {31'd0, win == 1});
    checkOutput("ram_we", {31'd0, ram_we}, {31'd0, exp_we});
    if (win >= 0) checkOutput("ram_addr", {18'd0, ram_addr}, {18'd0, ak[win]});
    if (exp_we)   checkOutput("ram_wdata", ram_wdata, dk[win]);
    checkOutput("rvalid0", {31'd0, rvalid0}, {31'd0, exp_rv[0] && !r});
    checkOutput("rvalid1", {31'd0, rvalid1}, {31'd0, exp_rv[1] && !r});
    if (exp_rv[0] && !r) checkOutput("rdata0", rdata0, exp_rd[0]);
    if (exp_rv[1] && !r) checkOutput("rdata1", rdata1, exp_rd[1]);

    for (int k = 0; k < 2; k++) begin
      exp_rv[k] = (win == k) && !wk[k];
      exp_rd[k] = ref_mem[ak[k]];
    end
    if (exp_we) ref_mem[ak[win]] = dk[win];

    if (r) begin
      m_owner = -1; m_streak = 0; m_last = 1;
    end else if (win >= 0) begin
      m_streak = (win == m_owner) ? ((m_streak < BM) ? m_streak + 1 : BM) : 1;
      m_owner  = win;
      m_last   = win;
    end else begin
      m_owner = -1; m_streak = 0;
    end
    seen_gnt[0] = gnt0;
    seen_gnt[1] = gnt1;

    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input logic r);
    applyStimulus(r, 0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  initial begin
    bit          h_req [2];
    bit          h_we  [2];
    logic [SIZE-1:0] h_addr [2];
    logic [31:0] h_data [2];

    for (int i = 0; i < (1 << SIZE); i++) begin
      mem[i]     = i * 3 + 7;
      ref_mem[i] = i * 3 + 7;
    end
    mem[150] = 9;  ref_mem[150] = 9;
    mem[151] = 5;  ref_mem[151] = 5;
    mem[152] = 12; ref_mem[152] = 12;
    m_owner = -1; m_streak = 0; m_last = 1;
    exp_rv[0] = 0; exp_rv[1] = 0; exp_rd[0] = '0; exp_rd[1] = '0;

    @(posedge clk); #1;
    // Reset held for a few cycles with requests present: nothing may be granted.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0, 14'd150, 14'd151, '0, '0);

    // Single reader, granted immediately after reset.
    applyStimulus(0, 1, 0, 0, 0, 14'd150, 14'd0, '0, '0);
    idleCycle(0);

    // Tie from reset: requester 0 first, bursts of BM alternate.
    applyStimulus(1, 0, 0, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 4 * BM + 2; i++) applyStimulus(0, 1, 1, 0, 0, 14'd151, 14'd152, '0, '0);
    idleCycle(0);

    // Write then read back through requester 1.
    applyStimulus(0, 0, 1, 0, 1, '0, 14'd98, '0, 32'h0000_0065);
    applyStimulus(0, 0, 1, 0, 0, '0, 14'd98, '0, '0);
    idleCycle(0);

    // Owner drops at streak 2 while requester 1 waits.
    applyStimulus(1, 0, 0, 0, 0, '0, '0, '0, '0);
    applyStimulus(0, 1, 0, 0, 0, 14'd100, 14'd101, '0, '0);
    applyStimulus(0, 1, 1, 0, 0, 14'd100, 14'd101, '0, '0);
    applyStimulus(0, 0, 1, 0, 0, 14'd100, 14'd101, '0, '0);
    for (int i = 0; i < BM + 1; i++) applyStimulus(0, 1, 1, 0, 0, 14'd100, 14'd101, '0, '0);
    idleCycle(0);

    // Reset lands right after a granted read, and again during a read request.
    applyStimulus(0, 1, 0, 0, 0, 14'd150, '0, '0, '0);
    applyStimulus(1, 1, 0, 0, 0, 14'd150, '0, '0, '0);
    applyStimulus(0, 1, 1, 0, 0, 14'd151, 14'd152, '0, '0);
    idleCycle(0);

    for (int i = 0; i < 10; i++) idleCycle(0);

    // Randomised traffic; an ungranted request is held unchanged until served.
    h_req[0] = 0; h_req[1] = 0;
    seen_gnt[0] = 0; seen_gnt[1] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!h_req[k] || seen_gnt[k]) begin
          h_req[k]  = ($urandom_range(0, 99) < 65);
          h_we[k]   = ($urandom_range(0, 99) < 35);
          h_addr[k] = SIZE'(90 + $urandom_range(0, 15));
          h_data[k] = $urandom;
        end
      end
      applyStimulus($urandom_range(0, 99) == 0, h_req[0], h_req[1], h_we[0], h_we[1],
                    h_addr[0], h_addr[1], h_data[0], h_data[1]);
    end
    idleCycle(0);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
